// File: rtl/fp_accum_sequencer.sv
// Serial FP32 reduction controller: folds NUM_TERMS input words into one sum
// through a single shared external FP_Adder, one addition in flight at a time.
module fp_accum_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TERMS  = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Clear,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_In,
  output logic [DATA_WIDTH-1:0] Add_A,
  output logic [DATA_WIDTH-1:0] Add_B,
  output logic                  Add_Valid,
  input  logic [DATA_WIDTH-1:0] Add_Result,
  input  logic                  Add_Valid_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Busy,
  output logic                  Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS);

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept;

  // Input handshake: a term transfers on any cycle where Valid_In and Ready_In
  // are both high; the producer keeps Data_In steady until that happens.
  assign Ready_In = (state == S_IDLE) || (state == S_COLLECT);
  assign accept   = Valid_In & Ready_In;
  assign Busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      Add_A     <= '0;
      Add_B     <= '0;
      Add_Valid <= 1'b0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Err       <= 1'b0;
    end else begin
      Add_Valid <= 1'b0;
      Valid_Out <= 1'b0;

      // A result with no addition outstanding means the adder and this block disagree.
      if (Add_Valid_Out &&
          (state == S_IDLE || state == S_COLLECT || state == S_DONE)) begin
        Err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (Clear) begin
            acc <= '0;
            cnt <= '0;
          end else if (accept) begin
            acc   <= Data_In;
            cnt   <= CNT_WIDTH'(1);
            state <= (NUM_TERMS == 1) ? S_DONE : S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (Clear) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end else if (accept) begin
            Add_A     <= acc;
            Add_B     <= Data_In;
            Add_Valid <= 1'b1;
            cnt       <= cnt + CNT_WIDTH'(1);
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (Clear) begin
            // An addition is in flight; if its result lands this very cycle it
            // is dropped here, otherwise DRAIN swallows it later.
            acc   <= '0;
            cnt   <= '0;
            state <= Add_Valid_Out ? S_IDLE : S_DRAIN;
          end else if (Add_Valid_Out) begin
            acc   <= Add_Result;
            state <= (cnt == LAST_CNT) ? S_DONE : S_COLLECT;
          end
        end

        S_DONE: begin
          if (Clear) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            Data_Out  <= acc;
            Valid_Out <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (Add_Valid_Out) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
